// File: rtl/axi_shim_arbiter.sv
// Round-robin arbiter that funnels NumPorts requesters onto one AXI-style shim.
// Read and write channels are identical, independent instances of axi_shim_arbiter_chan.

module axi_shim_arbiter_chan #(
   parameter int NumPorts       = 2,
   parameter int PortIdxW       = 1,
   parameter int LocIdW         = 3,
   parameter int PldWidth       = 64,
   parameter int MaxOutstanding = 4,
   parameter int CntW           = 3
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [NumPorts-1:0]                 req_i,
   output logic [NumPorts-1:0]                 gnt_o,
   input  logic [NumPorts-1:0][PldWidth-1:0]   pld_i,
   input  logic [NumPorts-1:0][LocIdW-1:0]     id_i,
   output logic                                shim_req_o,
   input  logic                                shim_gnt_i,
   output logic [PldWidth-1:0]                 shim_pld_o,
   output logic [PortIdxW+LocIdW-1:0]          shim_id_o,
   input  logic                                shim_valid_i,
   input  logic                                shim_last_i,
   input  logic [PortIdxW+LocIdW-1:0]          shim_rsp_id_i,
   output logic                                shim_rdy_o,
   output logic [NumPorts-1:0]                 valid_o,
   input  logic [NumPorts-1:0]                 rdy_i,
   output logic [LocIdW-1:0]                   id_o,
   output logic                                dbg_state_o,
   output logic [PortIdxW-1:0]                 dbg_rr_o,
   output logic [CntW-1:0]                     dbg_cnt_o
);

   typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [PortIdxW-1:0]   r_rr;
   logic [PortIdxW-1:0]   w_rr_next;
   logic [PortIdxW-1:0]   r_sel;
   logic [PortIdxW-1:0]   w_sel_next;
   logic [CntW-1:0]       r_cnt;
   logic [PortIdxW-1:0]   w_win;
   logic [PortIdxW-1:0]   w_port;
   logic                  w_any;
   logic                  w_cnt_ok;
   logic                  w_issue;
   logic                  w_done;
   logic [PortIdxW-1:0]   w_idx;
   logic                  w_idx_ok;

   function automatic logic [PortIdxW-1:0] f_next_port(input logic [PortIdxW-1:0] p);
      if (int'(p) == NumPorts - 1) return '0;
      else return p + PortIdxW'(1);
   endfunction

   // Scan from highest offset down so the closest requester at/after r_rr wins.
   always_comb begin
      w_win = r_rr;
      for (int k = NumPorts - 1; k >= 0; k--) begin
         if (req_i[(int'(r_rr) + k) % NumPorts]) w_win = PortIdxW'((int'(r_rr) + k) % NumPorts);
      end
   end

   assign w_any    = |req_i;
   assign w_cnt_ok = int'(r_cnt) < MaxOutstanding;

   always_comb begin
      w_next_state = r_state;
      w_rr_next    = r_rr;
      w_sel_next   = r_sel;
      w_port       = r_sel;
      gnt_o        = '0;
      shim_req_o   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_any && w_cnt_ok) begin
               shim_req_o = 1'b1;
               w_port     = w_win;
               if (shim_gnt_i) begin
                  gnt_o[w_win] = 1'b1;
                  w_rr_next    = f_next_port(w_win);
               end else begin
                  w_sel_next   = w_win;
                  w_next_state = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            shim_req_o = 1'b1;
            if (shim_gnt_i) begin
               gnt_o[r_sel] = 1'b1;
               w_rr_next    = f_next_port(r_sel);
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
      if (rst_i) begin
         gnt_o      = '0;
         shim_req_o = 1'b0;
      end
   end

   assign shim_pld_o = pld_i[w_port];
   assign shim_id_o  = {w_port, id_i[w_port]};

   // Responses route by the port index carried in the upper ID bits; unknown indices are sunk.
   assign w_idx    = shim_rsp_id_i[PortIdxW+LocIdW-1 -: PortIdxW];
   assign w_idx_ok = int'(w_idx) < NumPorts;
   assign id_o     = shim_rsp_id_i[LocIdW-1:0];

   always_comb begin
      valid_o    = '0;
      shim_rdy_o = 1'b1;
      if (!rst_i && w_idx_ok) begin
         valid_o[w_idx] = shim_valid_i;
         shim_rdy_o     = rdy_i[w_idx];
      end
   end

   assign w_issue = shim_req_o & shim_gnt_i;
   assign w_done  = shim_valid_i & shim_rdy_o & shim_last_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_rr    <= '0;
         r_sel   <= '0;
      end else begin
         r_state <= w_next_state;
         r_rr    <= w_rr_next;
         r_sel   <= w_sel_next;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt <= '0;
      end else if (w_issue && !w_done && r_cnt != '1) begin
         r_cnt <= r_cnt + CntW'(1);
      end else if (!w_issue && w_done && r_cnt != '0) begin
         r_cnt <= r_cnt - CntW'(1);
      end
   end

   assign dbg_state_o = r_state;
   assign dbg_rr_o    = r_rr;
   assign dbg_cnt_o   = r_cnt;

endmodule

module axi_shim_arbiter #(
   parameter int NumPorts       = 2,
   parameter int AxiIdWidth     = 4,
   parameter int RdPldWidth     = 64,
   parameter int WrPldWidth     = 128,
   parameter int RspPldWidth    = 66,
   parameter int MaxOutstanding = 4,
   localparam int PortIdxW      = (NumPorts > 2) ? $clog2(NumPorts) : 1,
   localparam int LocIdW        = AxiIdWidth - PortIdxW,
   localparam int CntW          = $clog2(MaxOutstanding + 1)
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [NumPorts-1:0]                   rd_req_i,
   output logic [NumPorts-1:0]                   rd_gnt_o,
   input  logic [NumPorts-1:0][RdPldWidth-1:0]   rd_pld_i,
   input  logic [NumPorts-1:0][LocIdW-1:0]       rd_id_i,
   input  logic [NumPorts-1:0]                   wr_req_i,
   output logic [NumPorts-1:0]                   wr_gnt_o,
   input  logic [NumPorts-1:0][WrPldWidth-1:0]   wr_pld_i,
   input  logic [NumPorts-1:0][LocIdW-1:0]       wr_id_i,
   output logic [NumPorts-1:0]                   rd_valid_o,
   input  logic [NumPorts-1:0]                   rd_rdy_i,
   output logic [RspPldWidth-1:0]                rd_rsp_o,
   output logic                                  rd_last_o,
   output logic [LocIdW-1:0]                     rd_id_o,
   output logic [NumPorts-1:0]                   wr_valid_o,
   input  logic [NumPorts-1:0]                   wr_rdy_i,
   output logic [LocIdW-1:0]                     wr_id_o,
   output logic                                  wr_exokay_o,
   output logic                                  shim_rd_req_o,
   input  logic                                  shim_rd_gnt_i,
   output logic [RdPldWidth-1:0]                 shim_rd_pld_o,
   output logic [AxiIdWidth-1:0]                 shim_rd_id_o,
   input  logic                                  shim_rd_valid_i,
   output logic                                  shim_rd_rdy_o,
   input  logic [RspPldWidth-1:0]                shim_rd_rsp_i,
   input  logic                                  shim_rd_last_i,
   input  logic [AxiIdWidth-1:0]                 shim_rd_id_i,
   output logic                                  shim_wr_req_o,
   input  logic                                  shim_wr_gnt_i,
   output logic [WrPldWidth-1:0]                 shim_wr_pld_o,
   output logic [AxiIdWidth-1:0]                 shim_wr_id_o,
   input  logic                                  shim_wr_valid_i,
   output logic                                  shim_wr_rdy_o,
   input  logic [AxiIdWidth-1:0]                 shim_wr_id_i,
   input  logic                                  shim_wr_exokay_i,
   output logic                                  dbg_rd_state_o,
   output logic [PortIdxW-1:0]                   dbg_rd_rr_o,
   output logic [CntW-1:0]                       dbg_rd_cnt_o,
   output logic                                  dbg_wr_state_o,
   output logic [PortIdxW-1:0]                   dbg_wr_rr_o,
   output logic [CntW-1:0]                       dbg_wr_cnt_o
);

   assign rd_rsp_o    = shim_rd_rsp_i;
   assign rd_last_o   = shim_rd_last_i;
   assign wr_exokay_o = shim_wr_exokay_i;

   axi_shim_arbiter_chan #(
      .NumPorts(NumPorts), .PortIdxW(PortIdxW), .LocIdW(LocIdW),
      .PldWidth(RdPldWidth), .MaxOutstanding(MaxOutstanding), .CntW(CntW)
   ) u_rd (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_i(rd_req_i), .gnt_o(rd_gnt_o), .pld_i(rd_pld_i), .id_i(rd_id_i),
      .shim_req_o(shim_rd_req_o), .shim_gnt_i(shim_rd_gnt_i),
      .shim_pld_o(shim_rd_pld_o), .shim_id_o(shim_rd_id_o),
      .shim_valid_i(shim_rd_valid_i), .shim_last_i(shim_rd_last_i),
      .shim_rsp_id_i(shim_rd_id_i), .shim_rdy_o(shim_rd_rdy_o),
      .valid_o(rd_valid_o), .rdy_i(rd_rdy_i), .id_o(rd_id_o),
      .dbg_state_o(dbg_rd_state_o), .dbg_rr_o(dbg_rd_rr_o), .dbg_cnt_o(dbg_rd_cnt_o)
   );

   // Each write response completes a whole burst, so "last" is always true here.
   axi_shim_arbiter_chan #(
      .NumPorts(NumPorts), .PortIdxW(PortIdxW), .LocIdW(LocIdW),
      .PldWidth(WrPldWidth), .MaxOutstanding(MaxOutstanding), .CntW(CntW)
   ) u_wr (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_i(wr_req_i), .gnt_o(wr_gnt_o), .pld_i(wr_pld_i), .id_i(wr_id_i),
      .shim_req_o(shim_wr_req_o), .shim_gnt_i(shim_wr_gnt_i),
      .shim_pld_o(shim_wr_pld_o), .shim_id_o(shim_wr_id_o),
      .shim_valid_i(shim_wr_valid_i), .shim_last_i(1'b1),
      .shim_rsp_id_i(shim_wr_id_i), .shim_rdy_o(shim_wr_rdy_o),
      .valid_o(wr_valid_o), .rdy_i(wr_rdy_i), .id_o(wr_id_o),
      .dbg_state_o(dbg_wr_state_o), .dbg_rr_o(dbg_wr_rr_o), .dbg_cnt_o(dbg_wr_cnt_o)
   );

endmodule

// File: tb/tb_axi_shim_arbiter.sv
// Directed bench for axi_shim_arbiter with default parameters (2 ports, 4-bit shim ID,
// MaxOutstanding 4); expected values are hand-computed constants.

module tb_axi_shim_arbiter;

   logic                 clk_i;
   logic                 rst_i;
   logic [1:0]           rd_req_i;
   logic [1:0]           rd_gnt_o;
   logic [1:0][63:0]     rd_pld_i;
   logic [1:0][2:0]      rd_id_i;
   logic [1:0]           wr_req_i;
   logic [1:0]           wr_gnt_o;
   logic [1:0][127:0]    wr_pld_i;
   logic [1:0][2:0]      wr_id_i;
   logic [1:0]           rd_valid_o;
   logic [1:0]           rd_rdy_i;
   logic [65:0]          rd_rsp_o;
   logic                 rd_last_o;
   logic [2:0]           rd_id_o;
   logic [1:0]           wr_valid_o;
   logic [1:0]           wr_rdy_i;
   logic [2:0]           wr_id_o;
   logic                 wr_exokay_o;
   logic                 shim_rd_req_o;
   logic                 shim_rd_gnt_i;
   logic [63:0]          shim_rd_pld_o;
   logic [3:0]           shim_rd_id_o;
   logic                 shim_rd_valid_i;
   logic                 shim_rd_rdy_o;
   logic [65:0]          shim_rd_rsp_i;
   logic                 shim_rd_last_i;
   logic [3:0]           shim_rd_id_i;
   logic                 shim_wr_req_o;
   logic                 shim_wr_gnt_i;
   logic [127:0]         shim_wr_pld_o;
   logic [3:0]           shim_wr_id_o;
   logic                 shim_wr_valid_i;
   logic                 shim_wr_rdy_o;
   logic [3:0]           shim_wr_id_i;
   logic                 shim_wr_exokay_i;
   logic                 dbg_rd_state_o;
   logic                 dbg_rd_rr_o;
   logic [2:0]           dbg_rd_cnt_o;
   logic                 dbg_wr_state_o;
   logic                 dbg_wr_rr_o;
   logic [2:0]           dbg_wr_cnt_o;

   int n_total = 0;
   int n_bad   = 0;

   localparam logic [63:0]  RdPld0 = 64'h0000_0000_0000_00A0;
   localparam logic [63:0]  RdPld1 = 64'h0000_0000_0000_00B1;
   localparam logic [127:0] WrPld0 = 128'h0000_0000_0000_0000_0000_0000_0001_1111;
   localparam logic [127:0] WrPld1 = 128'hCAFE_F00D_0000_0000_0123_4567_89AB_CDEF;
   localparam logic [65:0]  RspVal = 66'h2_DEAD_BEEF_0000_1234;

   axi_shim_arbiter dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .rd_req_i(rd_req_i), .rd_gnt_o(rd_gnt_o), .rd_pld_i(rd_pld_i), .rd_id_i(rd_id_i),
      .wr_req_i(wr_req_i), .wr_gnt_o(wr_gnt_o), .wr_pld_i(wr_pld_i), .wr_id_i(wr_id_i),
      .rd_valid_o(rd_valid_o), .rd_rdy_i(rd_rdy_i), .rd_rsp_o(rd_rsp_o),
      .rd_last_o(rd_last_o), .rd_id_o(rd_id_o),
      .wr_valid_o(wr_valid_o), .wr_rdy_i(wr_rdy_i), .wr_id_o(wr_id_o), .wr_exokay_o(wr_exokay_o),
      .shim_rd_req_o(shim_rd_req_o), .shim_rd_gnt_i(shim_rd_gnt_i),
      .shim_rd_pld_o(shim_rd_pld_o), .shim_rd_id_o(shim_rd_id_o),
      .shim_rd_valid_i(shim_rd_valid_i), .shim_rd_rdy_o(shim_rd_rdy_o),
      .shim_rd_rsp_i(shim_rd_rsp_i), .shim_rd_last_i(shim_rd_last_i), .shim_rd_id_i(shim_rd_id_i),
      .shim_wr_req_o(shim_wr_req_o), .shim_wr_gnt_i(shim_wr_gnt_i),
      .shim_wr_pld_o(shim_wr_pld_o), .shim_wr_id_o(shim_wr_id_o),
      .shim_wr_valid_i(shim_wr_valid_i), .shim_wr_rdy_o(shim_wr_rdy_o),
      .shim_wr_id_i(shim_wr_id_i), .shim_wr_exokay_i(shim_wr_exokay_i),
      .dbg_rd_state_o(dbg_rd_state_o), .dbg_rd_rr_o(dbg_rd_rr_o), .dbg_rd_cnt_o(dbg_rd_cnt_o),
      .dbg_wr_state_o(dbg_wr_state_o), .dbg_wr_rr_o(dbg_wr_rr_o), .dbg_wr_cnt_o(dbg_wr_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_i = 1'b1;
      rd_req_i = '0; wr_req_i = '0; rd_rdy_i = '0; wr_rdy_i = '0;
      rd_pld_i[0] = RdPld0; rd_pld_i[1] = RdPld1;
      rd_id_i[0] = 3'd5;    rd_id_i[1] = 3'd2;
      wr_pld_i[0] = WrPld0; wr_pld_i[1] = WrPld1;
      wr_id_i[0] = 3'd1;    wr_id_i[1] = 3'd6;
      shim_rd_gnt_i = 1'b0; shim_rd_valid_i = 1'b0; shim_rd_rsp_i = '0;
      shim_rd_last_i = 1'b0; shim_rd_id_i = '0;
      shim_wr_gnt_i = 1'b0; shim_wr_valid_i = 1'b0; shim_wr_id_i = '0; shim_wr_exokay_i = 1'b0;

      // Reset with live stimulus: everything must stay quiet, shim ready drains
      tick();
      rd_req_i = 2'b11; shim_rd_gnt_i = 1'b1; wr_req_i = 2'b11; shim_wr_gnt_i = 1'b1;
      shim_rd_valid_i = 1'b1; shim_rd_id_i = 4'h5; rd_rdy_i = 2'b00;
      #1;
      chk("rst_rd_gnt", rd_gnt_o, 2'b00);
      chk("rst_wr_gnt", wr_gnt_o, 2'b00);
      chk("rst_shim_rd_req", shim_rd_req_o, 1'b0);
      chk("rst_shim_wr_req", shim_wr_req_o, 1'b0);
      chk("rst_rd_valid", rd_valid_o, 2'b00);
      chk("rst_shim_rd_rdy", shim_rd_rdy_o, 1'b1);
      chk("rst_shim_wr_rdy", shim_wr_rdy_o, 1'b1);
      tick();
      chk("rst_rd_cnt", dbg_rd_cnt_o, 3'd0);
      chk("rst_rd_state", dbg_rd_state_o, 1'b0);
      chk("rst_rd_rr", dbg_rd_rr_o, 1'b0);

      // Round-robin with constant grant: 0,1,0,1 then stall at MaxOutstanding
      rst_i = 1'b0; wr_req_i = 2'b00; shim_wr_gnt_i = 1'b0;
      shim_rd_valid_i = 1'b0; shim_rd_id_i = '0;
      #1;
      chk("rr_pld0", shim_rd_pld_o, RdPld0);
      for (int i = 0; i < 4; i++) begin
         chk("rr_gnt", rd_gnt_o, (i % 2 == 1) ? 2'b10 : 2'b01);
         chk("rr_shim_id", shim_rd_id_o, (i % 2 == 1) ? 4'hA : 4'h5);
         tick();
         if (i == 0) chk("rr_pld1", shim_rd_pld_o, RdPld1);
      end
      chk("stall_req", shim_rd_req_o, 1'b0);
      chk("stall_gnt", rd_gnt_o, 2'b00);
      chk("stall_cnt", dbg_rd_cnt_o, 3'd4);
      chk("stall_rr", dbg_rd_rr_o, 1'b0);

      // One last beat for port 0 frees a slot on the following cycle
      shim_rd_valid_i = 1'b1; shim_rd_id_i = 4'h5; shim_rd_last_i = 1'b1;
      shim_rd_rsp_i = RspVal; rd_rdy_i = 2'b01;
      #1;
      chk("rsp_valid", rd_valid_o, 2'b01);
      chk("rsp_id", rd_id_o, 3'd5);
      chk("rsp_rdy", shim_rd_rdy_o, 1'b1);
      chk("rsp_data", rd_rsp_o, RspVal);
      chk("rsp_last", rd_last_o, 1'b1);
      chk("rsp_still_stalled", shim_rd_req_o, 1'b0);
      tick();
      shim_rd_valid_i = 1'b0;
      #1;
      chk("free_cnt", dbg_rd_cnt_o, 3'd3);
      chk("free_req", shim_rd_req_o, 1'b1);
      chk("free_gnt", rd_gnt_o, 2'b01);
      tick();
      rd_req_i = 2'b00;

      // Non-last beat leaves the counter alone
      shim_rd_valid_i = 1'b1; shim_rd_id_i = 4'hA; shim_rd_last_i = 1'b0; rd_rdy_i = 2'b10;
      #1;
      chk("beat_valid", rd_valid_o, 2'b10);
      chk("beat_id", rd_id_o, 3'd2);
      chk("beat_last", rd_last_o, 1'b0);
      tick();
      chk("beat_cnt", dbg_rd_cnt_o, 3'd4);

      // Backpressure from the requester propagates to the shim
      shim_rd_last_i = 1'b1; rd_rdy_i = 2'b00;
      #1;
      chk("bp_rdy", shim_rd_rdy_o, 1'b0);
      chk("bp_valid", rd_valid_o, 2'b10);
      tick();
      chk("bp_cnt", dbg_rd_cnt_o, 3'd4);
      rd_rdy_i = 2'b10;
      tick();
      tick();
      chk("drain_cnt", dbg_rd_cnt_o, 3'd2);

      // Grant and completion in the same cycle at cnt 2
      rd_req_i = 2'b01;
      #1;
      chk("same_gnt", rd_gnt_o, 2'b01);
      tick();
      chk("same_cnt", dbg_rd_cnt_o, 3'd2);
      chk("same_rr", dbg_rd_rr_o, 1'b1);
      rd_req_i = 2'b00; shim_rd_valid_i = 1'b0; rd_rdy_i = 2'b00;

      // Write HOLD: port 1 waits three cycles for the shim grant
      wr_req_i = 2'b10; shim_wr_gnt_i = 1'b0;
      #1;
      chk("hold_c1_req", shim_wr_req_o, 1'b1);
      chk("hold_c1_id", shim_wr_id_o, 4'hE);
      chk("hold_c1_pld", shim_wr_pld_o, WrPld1);
      chk("hold_c1_gnt", wr_gnt_o, 2'b00);
      chk("hold_c1_state", dbg_wr_state_o, 1'b0);
      tick();
      chk("hold_c2_state", dbg_wr_state_o, 1'b1);
      wr_req_i = 2'b11;
      #1;
      chk("hold_c2_id", shim_wr_id_o, 4'hE);
      chk("hold_c2_gnt", wr_gnt_o, 2'b00);
      tick();
      chk("hold_c3_state", dbg_wr_state_o, 1'b1);
      chk("hold_c3_pld", shim_wr_pld_o, WrPld1);
      tick();
      shim_wr_gnt_i = 1'b1;
      #1;
      chk("hold_c4_gnt", wr_gnt_o, 2'b10);
      chk("hold_c4_state", dbg_wr_state_o, 1'b1);
      tick();
      wr_req_i = 2'b00; shim_wr_gnt_i = 1'b0;
      #1;
      chk("hold_done_state", dbg_wr_state_o, 1'b0);
      chk("hold_done_rr", dbg_wr_rr_o, 1'b0);
      chk("hold_done_cnt", dbg_wr_cnt_o, 3'd1);

      // Write response routed to port 1 with local id 3
      shim_wr_valid_i = 1'b1; shim_wr_id_i = 4'hB; shim_wr_exokay_i = 1'b1; wr_rdy_i = 2'b00;
      #1;
      chk("wrsp_valid", wr_valid_o, 2'b10);
      chk("wrsp_id", wr_id_o, 3'd3);
      chk("wrsp_rdy", shim_wr_rdy_o, 1'b0);
      chk("wrsp_exokay", wr_exokay_o, 1'b1);
      tick();
      chk("wrsp_cnt_hold", dbg_wr_cnt_o, 3'd1);
      wr_rdy_i = 2'b10;
      #1;
      chk("wrsp_rdy_up", shim_wr_rdy_o, 1'b1);
      tick();
      shim_wr_valid_i = 1'b0; wr_rdy_i = 2'b00;
      #1;
      chk("wrsp_cnt_dec", dbg_wr_cnt_o, 3'd0);

      // Reset during write HOLD abandons the request
      wr_req_i = 2'b01; shim_wr_gnt_i = 1'b1;
      #1;
      chk("pre_gnt", wr_gnt_o, 2'b01);
      tick();
      wr_req_i = 2'b10; shim_wr_gnt_i = 1'b0;
      tick();
      chk("pre_hold_state", dbg_wr_state_o, 1'b1);
      chk("pre_hold_cnt", dbg_wr_cnt_o, 3'd1);
      rst_i = 1'b1; shim_wr_gnt_i = 1'b1;
      #1;
      chk("mid_rst_gnt", wr_gnt_o, 2'b00);
      chk("mid_rst_req", shim_wr_req_o, 1'b0);
      chk("mid_rst_rdy", shim_wr_rdy_o, 1'b1);
      tick();
      chk("post_rst_state", dbg_wr_state_o, 1'b0);
      chk("post_rst_cnt", dbg_wr_cnt_o, 3'd0);
      chk("post_rst_rr", dbg_wr_rr_o, 1'b0);
      rst_i = 1'b0; wr_req_i = 2'b11;
      #1;
      chk("post_rst_gnt", wr_gnt_o, 2'b01);
      chk("post_rst_id", shim_wr_id_o, 4'h1);
      tick();
      wr_req_i = 2'b00; shim_wr_gnt_i = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/axi_shim_arbiter.md
AXI_SHIM_ARBITER -- requirements
Module: axi_shim_arbiter

Interface
REQ-001 SHALL have parameter NumPorts, default 2, number of requesters (2..8).
REQ-002 SHALL have parameter AxiIdWidth, default 4, shim-side ID width; PortIdxW = max(1,$clog2(NumPorts)); requester ID width LocIdW = AxiIdWidth-PortIdxW (>=1).
REQ-003 SHALL have parameters RdPldWidth/WrPldWidth, default 64/128, opaque request payloads (addr, blen, size, lock, data, be, atop), and RspPldWidth, default 66, opaque read-response payload (data, user, last, exokay).
REQ-004 SHALL have parameter MaxOutstanding, default 4, per-channel issued-but-uncompleted limit.
REQ-005 clk_i  in  1  clock; all logic on rising edge.
REQ-006 rst_i  in  1  reset; synchronous, active-high.
REQ-007 rd_req_i/rd_gnt_o  in/out  [NumPorts]  per-port read request/grant; rd_pld_i  in  [NumPorts][RdPldWidth]; rd_id_i  in  [NumPorts][LocIdW].
REQ-008 wr_req_i/wr_gnt_o  in/out  [NumPorts]; wr_pld_i  in  [NumPorts][WrPldWidth]; wr_id_i  in  [NumPorts][LocIdW].
REQ-009 rd_valid_o/rd_rdy_i  out/in  [NumPorts]; rd_rsp_o  out  RspPldWidth; rd_last_o  out  1; rd_id_o  out  LocIdW (last/rsp/id broadcast).
REQ-010 wr_valid_o/wr_rdy_i  out/in  [NumPorts]; wr_id_o  out  LocIdW; wr_exokay_o  out  1 (broadcast).
REQ-011 shim_rd_req_o/shim_rd_gnt_i, shim_rd_pld_o [RdPldWidth], shim_rd_id_o [AxiIdWidth]; shim_rd_valid_i/shim_rd_rdy_o, shim_rd_rsp_i, shim_rd_last_i, shim_rd_id_i: shim read side.
REQ-012 shim_wr_req_o/shim_wr_gnt_i, shim_wr_pld_o, shim_wr_id_o; shim_wr_valid_i/shim_wr_rdy_o, shim_wr_id_i, shim_wr_exokay_i: shim write side.

Function (read and write channels identical and independent unless stated)
REQ-013 Each channel SHALL have FSM {IDLE, HOLD}, round-robin pointer rr_q (PortIdxW), outstanding counter cnt_q ($clog2(MaxOutstanding+1) bits).
REQ-014 IDLE, any req and cnt_q<MaxOutstanding: winner = first requesting port at or after rr_q (wrapping NumPorts-1 -> 0); shim_req_o=1, shim_pld_o=winner pld, shim_id_o={winner index, winner local id} same cycle.
REQ-015 IDLE, shim_gnt_i=1 same cycle: gnt_o[winner]=1, rr_q<=winner+1 mod NumPorts, stay IDLE; else latch sel_q<=winner, go HOLD.
REQ-016 HOLD: drive port sel_q unconditionally (no re-arbitration, counter limit not checked); on shim_gnt_i: gnt_o[sel_q]=1, rr_q<=sel_q+1 mod NumPorts, -> IDLE.
REQ-017 Requesters SHALL hold req and payload stable until granted; arbiter behaviour under withdrawal is undefined.
REQ-018 IDLE with cnt_q==MaxOutstanding: shim_req_o=0, all gnt_o=0, rr_q unchanged.
REQ-019 Combinational path shim_gnt_i -> gnt_o permitted (write grant arrives at end of burst).
REQ-020 cnt_q +1 on shim req&gnt; -1 on completion (read: valid&rdy&last; write: valid&rdy); both same cycle: unchanged; never wraps.
REQ-021 Response routing: idx = shim id[AxiIdWidth-1 -: PortIdxW]; valid_o[idx]=shim_valid_i, others 0; shim_rdy_o = rdy_i[idx]; id_o = shim id low LocIdW bits.
REQ-022 idx>=NumPorts: shim_rdy_o=1, all valid_o=0 (response sunk); still counted as completion.
REQ-023 Read response beats SHALL pass with zero latency, no buffering; non-last beats do not change cnt_q.

Reset
REQ-024 rst_i: both FSMs IDLE, rr_q=0, sel_q=0, cnt_q=0, effective next edge, including mid-HOLD (in-flight request abandoned).
REQ-025 During rst_i high: all gnt_o, valid_o, shim_req_o SHALL be 0; shim_rdy_o SHALL be 1 (drain).

Verification
REQ-026 Ports 0,1 both rd_req, shim_rd_gnt_i=1 constant -> grants alternate 0,1,0,1; shim_rd_id_o upper bit = granted port.
REQ-027 wr_req port1 only, shim_wr_gnt_i low 3 cycles then high -> HOLD 3 cycles, port1 payload stable, wr_gnt_o=2'b10 in cycle 4, rr_q=0.
REQ-028 MaxOutstanding=4, 4 read grants, no responses -> 5th request stalls shim_rd_req_o=0; one last beat -> request issued next cycle.
REQ-029 shim_wr_valid_i with id={1,local 3}, wr_rdy_i[1]=0 -> wr_valid_o=2'b10, wr_id_o=3, shim_wr_rdy_o=0; wr_rdy_i[1]=1 -> cnt_q-1.
REQ-030 rst_i asserted while write HOLD -> next cycle IDLE, cnt_q=0, no wr_gnt_o; after release port 0 wins first.
REQ-031 Grant and completion same cycle at cnt_q=2 -> cnt_q stays 2.
